// File: rtl/huffman_pkg.sv
// rtl/huffman_pkg.sv - shared defaults, FSM states and code-table entry type for the Huffman decoder
package huffman_pkg;

    localparam int HUFF_W  = 8;
    localparam int HUFF_NE = 16;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE,
        ERR
    } huff_state_t;

    // One code-table entry at the default word width; width==0 marks the entry invalid
    typedef struct packed {
        logic [HUFF_W-1:0] sym;
        logic [HUFF_W-1:0] code;
        logic [HUFF_W-1:0] width;
    } huff_entry_t;

endpackage

// File: rtl/huff_code_match.sv
// rtl/huff_code_match.sv - combinational code-table compare against the bit-buffer head, lowest index wins
module huff_code_match #(
    parameter int W  = 8,
    parameter int NE = 16,
    parameter int FW = $clog2(2*W+1)
) (
    input  logic [2*W-1:0] bits_i,
    input  logic [FW-1:0]  fill_i,
    input  logic [W-1:0]   code_i  [NE],
    input  logic [W-1:0]   width_i [NE],
    input  logic [W-1:0]   sym_i   [NE],
    output logic           hit_o,
    output logic [W-1:0]   sym_o,
    output logic [W-1:0]   width_o
);

    logic [W-1:0] head;
    logic [W-1:0] mask;

    // Scan from the highest index down so the lowest matching index is the last one assigned
    always_comb begin
        hit_o   = 1'b0;
        sym_o   = '0;
        width_o = '0;
        head    = '0;
        mask    = '0;
        for (int i = NE-1; i >= 0; i--) begin
            head = W'(bits_i >> (2*W - 32'(width_i[i])));
            mask = ~({W{1'b1}} << width_i[i]);
            if ((width_i[i] != '0) &&
                (32'(width_i[i]) <= W) &&
                (32'(width_i[i]) <= 32'(fill_i)) &&
                (head == (code_i[i] & mask))) begin
                hit_o   = 1'b1;
                sym_o   = sym_i[i];
                width_o = width_i[i];
            end
        end
    end

endmodule

// File: rtl/huffman_dec.sv
// rtl/huffman_dec.sv - single-channel Huffman decoder; HUFF_DEC_ERR_EN adds err_out and a sticky error state
module huffman_dec
    import huffman_pkg::*;
#(
    parameter int W  = HUFF_W,
    parameter int NE = HUFF_NE
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 d_req,
    input  logic [W-1:0]         d_in,
    input  logic                 en_in,
    input  logic                 last_in,
    input  logic [$clog2(W):0]   last_bits,
    input  logic [7:0]           n_conf,
    input  logic [W-1:0]         d_conf,
    input  logic [W-1:0]         h_conf,
    input  logic [W-1:0]         w_conf,
    input  logic                 en_conf,
    input  logic                 new_conf,
    input  logic                 conf_done,
    output logic [W-1:0]         d_out,
    output logic                 en_out,
    input  logic                 out_ready,
`ifdef HUFF_DEC_ERR_EN
    output logic                 err_out,
`endif
    output logic                 done
);

    localparam int FW   = $clog2(2*W+1);
    localparam int IDXW = $clog2(NE);
    localparam logic [FW-1:0] FILL_W = FW'(W);
`ifdef HUFF_DEC_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    huff_state_t    state_q, state_d;
    logic [2*W-1:0] bits_q, bits_d, bits_c, in_word;
    logic [FW-1:0]  fill_q, fill_d, fill_c, cons, n_acc;
    logic [W-1:0]   tbl_sym_q [NE], tbl_sym_d [NE];
    logic [W-1:0]   tbl_code_q[NE], tbl_code_d[NE];
    logic [W-1:0]   tbl_w_q   [NE], tbl_w_d   [NE];
    logic [W-1:0]   d_out_q, d_out_d, in_mask;
    logic           en_out_q, en_out_d;
    logic           hit, active, decode, bad, accept, any_valid;
    logic [W-1:0]   m_sym, m_width;

    huff_code_match #(.W(W), .NE(NE), .FW(FW)) u_match (
        .bits_i  (bits_q),
        .fill_i  (fill_q),
        .code_i  (tbl_code_q),
        .width_i (tbl_w_q),
        .sym_i   (tbl_sym_q),
        .hit_o   (hit),
        .sym_o   (m_sym),
        .width_o (m_width)
    );

    // Decode/accept qualifiers shared by datapath and FSM
    always_comb begin
        active    = (state_q == RUN) || (state_q == DRAIN);
        decode    = active && hit && (!en_out_q || out_ready);
        bad       = active && !hit && (fill_q >= FILL_W);
        accept    = en_in && d_req;
        any_valid = 1'b0;
        for (int i = 0; i < NE; i++) begin
            any_valid = any_valid | (tbl_w_q[i] != '0);
        end
    end

    // Bit buffer: consume the matched code (or one resync bit), then append the accepted word below the new fill
    always_comb begin
        cons = '0;
        if (decode) begin
            cons = FW'(m_width);
        end else if (bad && !ERR_EN) begin
            cons = FW'(1);
        end
        fill_c  = fill_q - cons;
        bits_c  = bits_q << cons;
        in_mask = last_in ? ~({W{1'b1}} >> last_bits) : {W{1'b1}};
        in_word = {d_in & in_mask, {W{1'b0}}};
        n_acc   = last_in ? FW'(last_bits) : FILL_W;
        bits_d  = bits_c;
        fill_d  = fill_c;
        if (accept) begin
            bits_d = bits_c | (in_word >> fill_c);
            fill_d = fill_c + n_acc;
        end
        if (new_conf || (state_q == IDLE) || (state_q == DONE)) begin
            bits_d = '0;
            fill_d = '0;
        end
    end

    // Code table: cleared by new_conf, written only while idle
    always_comb begin
        tbl_sym_d  = tbl_sym_q;
        tbl_code_d = tbl_code_q;
        tbl_w_d    = tbl_w_q;
        if (new_conf) begin
            for (int i = 0; i < NE; i++) begin
                tbl_sym_d[i]  = '0;
                tbl_code_d[i] = '0;
                tbl_w_d[i]    = '0;
            end
        end else if (en_conf && (state_q == IDLE)) begin
            tbl_sym_d[n_conf[IDXW-1:0]]  = d_conf;
            tbl_code_d[n_conf[IDXW-1:0]] = h_conf;
            tbl_w_d[n_conf[IDXW-1:0]]    = w_conf;
        end
    end

    // Output register: a new symbol loads when the slot is empty or being taken this cycle
    always_comb begin
        d_out_d  = d_out_q;
        en_out_d = en_out_q;
        if (decode) begin
            d_out_d  = m_sym;
            en_out_d = 1'b1;
        end else if (out_ready) begin
            en_out_d = 1'b0;
        end
        if (new_conf) begin
            en_out_d = 1'b0;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (conf_done && any_valid) state_d = RUN;
            RUN: begin
                if (bad && ERR_EN)             state_d = ERR;
                else if (accept && last_in)    state_d = DRAIN;
            end
            DRAIN: begin
                if (!hit && (fill_q < FILL_W)) state_d = DONE;
                else if (bad && ERR_EN)        state_d = ERR;
            end
            DONE:    state_d = RUN;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
        if (new_conf) begin
            state_d = IDLE;
        end
    end

    // FSM outputs
    always_comb begin
        d_req = (state_q == RUN) && (fill_q <= FILL_W);
        done  = (state_q == DONE);
`ifdef HUFF_DEC_ERR_EN
        err_out = (state_q == ERR);
`endif
    end

    assign d_out  = d_out_q;
    assign en_out = en_out_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bits_q   <= '0;
            fill_q   <= '0;
            d_out_q  <= '0;
            en_out_q <= 1'b0;
            for (int i = 0; i < NE; i++) begin
                tbl_sym_q[i]  <= '0;
                tbl_code_q[i] <= '0;
                tbl_w_q[i]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            bits_q     <= bits_d;
            fill_q     <= fill_d;
            d_out_q    <= d_out_d;
            en_out_q   <= en_out_d;
            tbl_sym_q  <= tbl_sym_d;
            tbl_code_q <= tbl_code_d;
            tbl_w_q    <= tbl_w_d;
        end
    end

endmodule
